// File: rtl/rv_pkg.sv
// Shared constants and types for the RISC-V fetch front end.
package rv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

  // Canonical no-op (addi x0, x0, 0).
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  // One buffered fetch: the instruction word tagged with its PC.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv_sync_fifo.sv
// Generic synchronous FIFO: push/pop/flush, occupancy count and head data.
module rv_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: storage is cleared on reset so the head data reads 0 out of reset;
      // this costs a reset net per bit and is kept only because it is visible.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this block
      // sees the pre-edge value regardless of statement order.
      if (push_i) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (pop_i) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(push_i) - CW'(pop_i);
    end
  end

  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];

  // The producer's credit scheme must keep these from ever happening.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !flush_i && r_count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && !flush_i && r_count == '0));

endmodule

// File: rtl/rv_fetch_buf.sv
// Instruction fetch buffer: credit-limited sequential fetch into a FIFO,
// drained by decode; redirects flush the queue and drop in-flight responses.
module rv_fetch_buf #(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    imem_req_o,
  output logic [XLEN-1:0]         imem_addr_o,
  input  logic                    imem_gnt_i,
  input  logic                    imem_rvalid_i,
  input  logic [rv_pkg::ILEN-1:0] imem_rdata_i,
  input  logic                    redirect_i,
  input  logic [XLEN-1:0]         redirect_pc_i,
  output logic                    instr_valid_o,
  output logic [rv_pkg::ILEN-1:0] instr_o,
  output logic [XLEN-1:0]         pc_o,
  input  logic                    instr_ready_i
);

  localparam int unsigned ILEN = rv_pkg::ILEN;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam int unsigned EW   = XLEN + ILEN;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_inflight;
  logic            w_gnt;
  logic            w_rsp;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_pc;
  logic [EW-1:0]   w_head;

  // Entries that will occupy the FIFO once every live request returns;
  // doomed responses are excluded. One extra bit so the sum cannot wrap.
  assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding} - {1'b0, r_drop_cnt};

  // Credit check uses registered state only: a same-cycle pop frees nothing.
  assign imem_req_o  = !rst_i && !redirect_i
                     && (r_outstanding < CW'(DEPTH))
                     && (w_inflight < (CW+1)'(DEPTH));
  assign imem_addr_o = r_fetch_pc;

  assign w_gnt  = imem_req_o && imem_gnt_i;
  assign w_rsp  = imem_rvalid_i && !redirect_i;
  assign w_drop = w_rsp && (r_drop_cnt != '0);
  assign w_push = w_rsp && (r_drop_cnt == '0);
  assign w_pop  = instr_valid_o && instr_ready_i && !redirect_i;

  assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

  // PC registers, outstanding-request credit and the drop counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_outstanding <= r_outstanding - CW'(imem_rvalid_i);
      r_drop_cnt    <= r_outstanding - CW'(imem_rvalid_i);
    end else begin
      if (w_gnt)  r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_push) r_resp_pc  <= r_resp_pc + XLEN'(4);
      r_outstanding <= r_outstanding + CW'(w_gnt) - CW'(imem_rvalid_i);
      if (w_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  rv_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  ({r_resp_pc, imem_rdata_i}),
    .pop_i   (w_pop),
    .flush_i (redirect_i),
    .count_o (w_count),
    .data_o  (w_head)
  );

  assign instr_valid_o     = (w_count != '0);
  assign {pc_o, instr_o}   = w_head;

endmodule

// File: tb/tb_rv_fetch_buf.sv
// Self-checking bench for rv_fetch_buf: an imem responder with random grant
// and response latency, and a reference model of the architectural stream.
module tb_rv_fetch_buf;
  import rv_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            imem_req_o;
  logic [63:0]     imem_addr_o;
  logic            imem_gnt_i = 1'b0;
  logic            imem_rvalid_i = 1'b0;
  logic [31:0]     imem_rdata_i = '0;
  logic            redirect_i = 1'b0;
  logic [63:0]     redirect_pc_i = '0;
  logic            instr_valid_o;
  logic [31:0]     instr_o;
  logic [63:0]     pc_o;
  logic            instr_ready_i = 1'b0;

  rv_fetch_buf #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int unsigned gnt_pct  = 0;
  int unsigned rsp_pct  = 0;

  // Reference model: the next address imem should see and the next PC decode should see.
  logic [63:0] m_fetch;
  logic [63:0] m_vis;
  logic [63:0] pend_addr[$];
  int          pend_cyc[$];

  int          n_grants;
  int          n_pops;
  int          first_grant_cyc;
  int          first_valid_cyc;
  bit          have_first_pop;
  logic [63:0] first_pop_pc;

  // Memory contents: distinct word per address (odd multiplier is a bijection).
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  // One clock: drive imem, sample the DUT pre-edge, advance, update the model.
  task automatic cycle();
    logic         s_req;
    logic [63:0]  s_addr;
    logic         s_valid;
    fetch_entry_t s_head;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (!rst_i && pend_addr.size() > 0 && pend_cyc[0] < cyc &&
        $urandom_range(99) < rsp_pct) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = instr_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
    end
    imem_gnt_i = ($urandom_range(99) < gnt_pct);
    #1;
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = instr_valid_o;
    s_head  = '{pc: pc_o, instr: instr_o};
    if (rst_i) begin
      n_checks++;
      if (s_req !== 1'b0) begin
        n_fail++;
        $display("FAIL req_in_reset: got %b expected 0", s_req);
      end
    end
    if (s_req === 1'b1 && imem_gnt_i) begin
      n_checks++;
      if (s_addr !== m_fetch) begin
        n_fail++;
        $display("FAIL grant_addr: got %h expected %h (cycle %0d)", s_addr, m_fetch, cyc);
      end
      n_checks++;
      if (pend_addr.size() >= DEPTH) begin
        n_fail++;
        $display("FAIL credit_limit: outstanding %0d expected < %0d", pend_addr.size(), DEPTH);
      end
      pend_addr.push_back(s_addr);
      pend_cyc.push_back(cyc);
      m_fetch = m_fetch + 64'd4;
      n_grants++;
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
    end
    if (s_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (s_valid === 1'b1 && instr_ready_i && !redirect_i && !rst_i) begin
      n_checks++;
      if (s_head.pc !== m_vis || s_head.instr !== instr_of(m_vis)) begin
        n_fail++;
        $display("FAIL pop_entry: got pc=%h instr=%h expected pc=%h instr=%h",
                 s_head.pc, s_head.instr, m_vis, instr_of(m_vis));
      end
      if (!have_first_pop) begin
        have_first_pop = 1'b1;
        first_pop_pc   = s_head.pc;
      end
      m_vis = m_vis + 64'd4;
      n_pops++;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    if (rst_i) begin
      pend_addr.delete();
      pend_cyc.delete();
      m_fetch = RESET_PC;
      m_vis   = RESET_PC;
    end else if (redirect_i) begin
      m_fetch = redirect_pc_i & ~64'd3;
      m_vis   = redirect_pc_i & ~64'd3;
    end
  endtask

  task automatic clear_stats();
    n_grants        = 0;
    n_pops          = 0;
    first_grant_cyc = -1;
    first_valid_cyc = -1;
    have_first_pop  = 1'b0;
    first_pop_pc    = '0;
  endtask

  task automatic do_reset();
    redirect_i    = 1'b0;
    instr_ready_i = 1'b0;
    gnt_pct       = 0;
    rsp_pct       = 0;
    rst_i         = 1'b1;
    cycle();
    rst_i = 1'b0;
    clear_stats();
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    cycle();
    redirect_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_stats();
    cycle();
    cycle();
    n_checks++;
    if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b instr=%h pc=%h expected 0/0/0",
               instr_valid_o, instr_o, pc_o);
    end
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h expected 1/%h",
               imem_req_o, imem_addr_o, RESET_PC);
    end
    clear_stats();
  endtask

  task automatic test_stream();
    do_reset();
    gnt_pct = 100; rsp_pct = 100; instr_ready_i = 1'b1;
    repeat (20) cycle();
    n_checks++;
    if (first_valid_cyc - first_grant_cyc !== 2) begin
      n_fail++;
      $display("FAIL stream_latency: got %0d expected 2", first_valid_cyc - first_grant_cyc);
    end
    n_checks++;
    if (n_pops !== 18) begin
      n_fail++;
      $display("FAIL stream_throughput: got %0d pops expected 18", n_pops);
    end
    n_checks++;
    if (first_pop_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL stream_first_pc: got %h expected %h", first_pop_pc, RESET_PC);
    end
  endtask

  task automatic test_credit();
    do_reset();
    gnt_pct = 100; rsp_pct = 100;
    repeat (10) cycle();
    n_checks++;
    if (n_grants !== 4 || imem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_full: got grants=%0d req=%b expected 4/0", n_grants, imem_req_o);
    end
    n_checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== RESET_PC) begin
      n_fail++;
      $display("FAIL credit_head: got valid=%b pc=%h expected 1/%h", instr_valid_o, pc_o, RESET_PC);
    end
    gnt_pct = 0; instr_ready_i = 1'b1;
    cycle();
    instr_ready_i = 1'b0;
    #1;
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC + 64'd16) begin
      n_fail++;
      $display("FAIL credit_refill: got req=%b addr=%h expected 1/%h",
               imem_req_o, imem_addr_o, RESET_PC + 64'd16);
    end
    gnt_pct = 100;
    cycle();
    n_checks++;
    if (n_grants !== 5 || imem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_one_more: got grants=%0d req=%b expected 5/0", n_grants, imem_req_o);
    end
    instr_ready_i = 1'b1;
    repeat (12) cycle();
  endtask

  task automatic test_redirect_drop();
    do_reset();
    gnt_pct = 100;
    repeat (3) cycle();
    gnt_pct = 0;
    redirect_to(64'h0000_0000_8000_0100);
    n_checks++;
    if (instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_flushed: got valid=%b expected 0", instr_valid_o);
    end
    rsp_pct = 100;
    repeat (5) cycle();
    n_checks++;
    if (instr_valid_o !== 1'b0 || imem_addr_o !== 64'h0000_0000_8000_0100) begin
      n_fail++;
      $display("FAIL drop_invisible: got valid=%b addr=%h expected 0/%h",
               instr_valid_o, imem_addr_o, 64'h0000_0000_8000_0100);
    end
    gnt_pct = 100; instr_ready_i = 1'b1;
    repeat (10) cycle();
    n_checks++;
    if (!have_first_pop || first_pop_pc !== 64'h0000_0000_8000_0100) begin
      n_fail++;
      $display("FAIL drop_first_pc: got %h expected %h", first_pop_pc, 64'h0000_0000_8000_0100);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    gnt_pct = 100;
    repeat (3) cycle();
    gnt_pct = 0; rsp_pct = 100;
    cycle();
    n_checks++;
    if (instr_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rv_setup: got valid=%b expected 1", instr_valid_o);
    end
    instr_ready_i = 1'b1;
    redirect_to(64'h0000_0000_8000_0300);
    instr_ready_i = 1'b0;
    n_checks++;
    if (instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rv_flush: got valid=%b expected 0", instr_valid_o);
    end
    cycle();
    n_checks++;
    if (instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rv_dropped: got valid=%b expected 0", instr_valid_o);
    end
    gnt_pct = 100; instr_ready_i = 1'b1;
    repeat (8) cycle();
    n_checks++;
    if (!have_first_pop || first_pop_pc !== 64'h0000_0000_8000_0300) begin
      n_fail++;
      $display("FAIL rv_first_pc: got %h expected %h", first_pop_pc, 64'h0000_0000_8000_0300);
    end
  endtask

  task automatic test_redirect_align();
    do_reset();
    redirect_to(64'h0000_0000_8000_0203);
    #1;
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0000_0000_8000_0200) begin
      n_fail++;
      $display("FAIL align_addr: got req=%b addr=%h expected 1/%h",
               imem_req_o, imem_addr_o, 64'h0000_0000_8000_0200);
    end
    gnt_pct = 100; rsp_pct = 100;
    cycle();
    redirect_to(64'h0000_0000_8000_0100);
    redirect_to(64'h0000_0000_8000_0200);
    instr_ready_i = 1'b1;
    repeat (8) cycle();
    n_checks++;
    if (!have_first_pop || first_pop_pc !== 64'h0000_0000_8000_0200) begin
      n_fail++;
      $display("FAIL b2b_first_pc: got %h expected %h", first_pop_pc, 64'h0000_0000_8000_0200);
    end
    clear_stats();
    redirect_to(64'hFFFF_FFFF_FFFF_FFFF);
    repeat (8) cycle();
    n_checks++;
    if (first_pop_pc !== 64'hFFFF_FFFF_FFFF_FFFC || n_pops < 3) begin
      n_fail++;
      $display("FAIL wrap_stream: got first=%h pops=%0d expected %h and >=3",
               first_pop_pc, n_pops, 64'hFFFF_FFFF_FFFF_FFFC);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    gnt_pct = 100;
    repeat (4) cycle();
    gnt_pct = 0; rsp_pct = 100;
    repeat (2) cycle();
    rsp_pct = 0;
    rst_i = 1'b1;
    cycle();
    n_checks++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: got valid=%b req=%b expected 0/0", instr_valid_o, imem_req_o);
    end
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      n_fail++;
      $display("FAIL midreset_req: got req=%b addr=%h expected 1/%h", imem_req_o, imem_addr_o, RESET_PC);
    end
    clear_stats();
    gnt_pct = 100; rsp_pct = 100; instr_ready_i = 1'b1;
    repeat (10) cycle();
    n_checks++;
    if (first_pop_pc !== RESET_PC || n_pops < 5) begin
      n_fail++;
      $display("FAIL midreset_stream: got first=%h pops=%0d expected %h and >=5",
               first_pop_pc, n_pops, RESET_PC);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      gnt_pct       = 70;
      rsp_pct       = 60;
      instr_ready_i = ($urandom_range(99) < 70);
      if ($urandom_range(999) < 2) begin
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
      end else if ($urandom_range(99) < 3) begin
        redirect_to(RESET_PC + 64'($urandom_range(4095)));
      end else begin
        cycle();
      end
    end
    gnt_pct = 0; rsp_pct = 100; instr_ready_i = 1'b1;
    repeat (20) cycle();
    n_checks++;
    if (instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got valid=%b expected 0", instr_valid_o);
    end
  endtask

  initial begin
    m_fetch = RESET_PC;
    m_vis   = RESET_PC;
    test_reset();
    test_stream();
    test_credit();
    test_redirect_drop();
    test_redirect_rvalid();
    test_redirect_align();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
